half_adder: RTL and testbench
=============================

Name: half_adder

Overview:
- Bit-parallel half-adder array with a registered, valid-qualified output pipeline.
- Each of WIDTH lanes independently computes sum = a XOR b and carry = a AND b.
- Results emerge STAGES clock cycles after capture.
- Used as a primitive arithmetic stage in lab datapaths and as a building block for full adders and ripple/carry-save structures.

Parameters:
- WIDTH, 1, number of independent half-adder lanes; legal range 1..64.
- STAGES, 1, pipeline depth in clock cycles from input capture to output; legal range 1..4. Out-of-range values are a compile-time error (elaboration assertion).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- en  input  1  pipeline advance enable; when low, all pipeline registers hold.
- in_valid  input  1  marks a, b as a valid operand pair this cycle.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- out_valid  output  1  s, c hold a valid result.
- s  output  WIDTH  per-lane sum bit, a[i] XOR b[i].
- c  output  WIDTH  per-lane carry bit, a[i] AND b[i].

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on the rising edge of clk.
  - Reset is synchronous and active-high: when rst=1 at a rising edge, every pipeline stage clears.
  - After reset, out_valid=0, s=0 and c=0 from the next edge onward.
  - rst has priority over en and in_valid.
- Per-lane function:
  - s[i] = a[i] ^ b[i]; c[i] = a[i] & b[i].
  - Lanes are fully independent; there is no carry propagation between lanes.
- Truth table per lane (a,b -> s,c): 0,0 -> 0,0; 0,1 -> 1,0; 1,0 -> 1,0; 1,1 -> 0,1.
- Invariant: s[i] and c[i] are never both 1.
- Computation point: compute at the input side, then carry the result through STAGES registers. The result is registered, so no combinational path runs from a/b to s/c.
- Pipeline advance (en=1 at an edge, rst=0):
  - Stage 0 captures in_valid together with the computed s/c.
  - Each later stage copies the previous one.
  - Outputs are driven from the last stage.
- Latency: with en held at 1, an operand pair presented at edge k appears on s/c with out_valid=1 after edge k+STAGES-1. That is, it is visible during the cycle following the STAGES-th capturing edge. With STAGES=1, the result is visible in the cycle after capture.
- Throughput: one operand pair per cycle; back-to-back valid inputs produce back-to-back valid outputs in order.
- Stall (en=0): every stage holds, including valid bits; outputs remain stable. Inputs presented while en=0 are ignored and not captured.
- in_valid=0 with en=1: a bubble enters the pipeline, and out_valid=0 emerges at the corresponding output cycle.
- Data payload when invalid: the pipeline still registers a XOR b and a AND b whatever in_valid is. Consumers must qualify s/c with out_valid.
- Reset mid-operation: all in-flight results are discarded. out_valid stays 0 until a new valid pair has traversed the full pipeline.
- Unknown (X) inputs while in_valid=0 must not corrupt valid flags.

Test Plan:
- Exhaustive truth table, WIDTH=1, STAGES=1, en=1: apply (a,b)=(0,0),(0,1),(1,0),(1,1) on consecutive cycles with in_valid=1 -> one cycle later each, (s,c)=(0,0),(1,0),(1,0),(0,1) with out_valid=1.
- Reset behaviour: drive a=1, b=1, in_valid=1, then assert rst for one edge -> out_valid=0, s=0, c=0 after that edge. The in-flight result must not appear afterwards.
- Multi-lane, WIDTH=8, STAGES=3: a=8'hF0, b=8'hAA, in_valid=1 for one cycle -> after 3 edges, s=8'h5A, c=8'hA0, out_valid=1 for exactly one cycle.
- Stall: with STAGES=2, send a=1, b=0, then hold en=0 for 4 cycles while toggling a/b -> outputs and out_valid frozen. Resuming en=1 delivers s=1, c=0 with no extra or lost results.
- Bubbles: in_valid pattern 1,0,1 with a=b=1 -> out_valid pattern 1,0,1 at STAGES latency, with s=0, c=1 on the valid cycles.
- Randomized consistency: 1000 random valid pairs, WIDTH=16 -> every output satisfies s==a^b, c==a&b, and (s&c)==0.

Source files
------------

// File: rtl/half_adder.sv
// half_adder: WIDTH-lane half adder with a STAGES-deep valid-qualified register pipeline.
module half_adder #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c
);
    if (WIDTH < 1 || WIDTH > 64 || STAGES < 1 || STAGES > 4) begin : g_bad_param
        $error("half_adder: WIDTH must be 1..64 and STAGES 1..4");
    end
    logic [STAGES-1:0] v_q, v_d;
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [WIDTH-1:0]  c_q [STAGES];
    logic [WIDTH-1:0]  c_d [STAGES];
    // Stage 0 takes the freshly computed result; later stages shift it along.
    always_comb begin
        v_d[0] = in_valid;
        s_d[0] = a ^ b;
        c_d[0] = a & b;
        for (int i = 1; i < STAGES; i++) begin
            v_d[i] = v_q[i-1];
            s_d[i] = s_q[i-1];
            c_d[i] = c_q[i-1];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                s_q[i] <= '0;
                c_q[i] <= '0;
            end
        end else if (en) begin
            v_q <= v_d;
            for (int i = 0; i < STAGES; i++) begin
                s_q[i] <= s_d[i];
                c_q[i] <= c_d[i];
            end
        end
    end
    assign out_valid = v_q[STAGES-1];
    assign s         = s_q[STAGES-1];
    assign c         = c_q[STAGES-1];
endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: directed checks of half_adder across three parameterisations sharing control inputs.
module tb_half_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        in_valid = 1'b0;
    logic        a1 = 1'b0, b1 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        v1, s1, c1, v8, v16;
    logic [7:0]  s8, c8;
    logic [15:0] s16, c16;
    int checks = 0;
    int failures = 0;
    logic [15:0] ea [1000];
    logic [15:0] eb [1000];
    logic [1:0]  tt_ab [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic        tt_s [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic        tt_c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic        bub_iv [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        bub_ov [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    half_adder #(.WIDTH(1), .STAGES(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .a(a1), .b(b1),
        .out_valid(v1), .s(s1), .c(c1)
    );
    half_adder #(.WIDTH(8), .STAGES(3)) u3 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .a(a8), .b(b8),
        .out_valid(v8), .s(s8), .c(c8)
    );
    half_adder #(.WIDTH(16), .STAGES(2)) u2 (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .a(a16), .b(b16),
        .out_valid(v16), .s(s16), .c(c16)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        check("rst_v1", 64'(v1), 64'(0));
        check("rst_s1", 64'(s1), 64'(0));
        check("rst_c1", 64'(c1), 64'(0));
        check("rst_v8", 64'(v8), 64'(0));
        check("rst_s8", 64'(s8), 64'(0));
        check("rst_v16", 64'(v16), 64'(0));
        rst = 1'b0;
        // Exhaustive truth table on the single-lane, single-stage instance.
        for (int i = 0; i < 4; i++) begin
            a1 = tt_ab[i][1];
            b1 = tt_ab[i][0];
            in_valid = 1'b1;
            tick();
            check("tt_v", 64'(v1), 64'(1));
            check("tt_s", 64'(s1), 64'(tt_s[i]));
            check("tt_c", 64'(c1), 64'(tt_c[i]));
        end
        // Reset wins over a simultaneous valid input and flushes in-flight work.
        a1 = 1'b1; b1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; in_valid = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_v1", 64'(v1), 64'(0));
        check("mid_rst_s1", 64'(s1), 64'(0));
        check("mid_rst_c1", 64'(c1), 64'(0));
        check("mid_rst_v8", 64'(v8), 64'(0));
        rst = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_v8", 64'(v8), 64'(0));
            check("post_rst_v1", 64'(v1), 64'(0));
        end
        // Multi-lane pattern through three stages, valid for exactly one cycle.
        a8 = 8'hF0; b8 = 8'hAA; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("ml_v_e0", 64'(v8), 64'(0));
        tick();
        check("ml_v_e1", 64'(v8), 64'(0));
        tick();
        check("ml_v_e2", 64'(v8), 64'(1));
        check("ml_s", 64'(s8), 64'(8'h5A));
        check("ml_c", 64'(c8), 64'(8'hA0));
        tick();
        check("ml_v_e3", 64'(v8), 64'(0));
        // Stall: first result sits on the output, second is mid-pipe, inputs toggle meanwhile.
        a16 = 16'h0001; b16 = 16'h0000; in_valid = 1'b1;
        tick();
        a16 = 16'h0003; b16 = 16'h0001;
        tick();
        check("st_pre_v", 64'(v16), 64'(1));
        check("st_pre_s", 64'(s16), 64'(16'h0001));
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); in_valid = i[0];
            tick();
            check("st_hold_v", 64'(v16), 64'(1));
            check("st_hold_s", 64'(s16), 64'(16'h0001));
            check("st_hold_c", 64'(c16), 64'(16'h0000));
        end
        en = 1'b1; in_valid = 1'b0;
        tick();
        check("st_res_v", 64'(v16), 64'(1));
        check("st_res_s", 64'(s16), 64'(16'h0002));
        check("st_res_c", 64'(c16), 64'(16'h0001));
        tick();
        check("st_end_v0", 64'(v16), 64'(0));
        tick();
        check("st_end_v1", 64'(v16), 64'(0));
        // Bubbles through the three-stage instance.
        a8 = 8'hFF; b8 = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            in_valid = bub_iv[i];
            tick();
            check("bub_v", 64'(v8), 64'(bub_ov[i]));
            if (bub_ov[i]) begin
                check("bub_s", 64'(s8), 64'(8'h00));
                check("bub_c", 64'(c8), 64'(8'hFF));
            end
        end
        // Back-to-back random pairs; each appears one iteration after it is presented.
        for (int i = 0; i < 1002; i++) begin
            if (i < 1000) begin
                ea[i] = 16'($urandom);
                eb[i] = 16'($urandom);
                a16 = ea[i]; b16 = eb[i]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (i >= 1) begin
                check("rnd_v", 64'(v16), 64'(i <= 1000));
                if (i <= 1000) begin
                    check("rnd_s", 64'(s16), 64'(ea[i-1] ^ eb[i-1]));
                    check("rnd_c", 64'(c16), 64'(ea[i-1] & eb[i-1]));
                    check("rnd_excl", 64'(s16 & c16), 64'(0));
                end
            end
        end
        // Unknown operands with in_valid low must leave every valid flag clean.
        in_valid = 1'b0; a1 = 'x; b1 = 'x; a8 = 'x; b8 = 'x; a16 = 'x; b16 = 'x;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("x_v1", 64'(v1), 64'(0));
            check("x_v8", 64'(v8), 64'(0));
            check("x_v16", 64'(v16), 64'(0));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
